// File: rtl/dm_responder.sv
// Data-memory responder: serves core read/write requests from an internal
// word array with a configurable access latency and ready/error pulses.
module dm_responder #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4096,
  parameter int LATENCY    = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  DM_enable,
  input  logic                  DM_read,
  input  logic                  DM_write,
  input  logic [ADDR_WIDTH-1:0] DM_address,
  input  logic [DATA_WIDTH-1:0] DM_in,
  output logic [DATA_WIDTH-1:0] DM_out,
  output logic                  DM_ready,
  output logic                  DM_error
);

  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int MW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                state, next_state;
  logic [CW-1:0]         cnt;
  logic [MW-1:0]         cap_addr;
  logic [DATA_WIDTH-1:0] cap_data;
  logic                  cap_write;
  logic                  err;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic open, addr_ok, req_valid, accept, reject, done;

  always_comb begin
    open      = (state == IDLE) || (state == RESP);
    // Full-width unsigned compare: addresses at or above DEPTH never alias.
    addr_ok   = {1'b0, DM_address} < (ADDR_WIDTH + 1)'(DEPTH);
    req_valid = DM_enable && (DM_read ^ DM_write) && addr_ok;
    accept    = open && req_valid;
    reject    = open && DM_enable && !req_valid;
    done      = (state == BUSY) && (cnt == '0);
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE, RESP: next_state = accept ? BUSY : IDLE;
      BUSY:       if (done) next_state = RESP;
      default:    next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt       <= '0;
      cap_addr  <= '0;
      cap_data  <= '0;
      cap_write <= 1'b0;
      err       <= 1'b0;
      DM_out    <= '0;
    end else begin
      err <= reject;
      if (accept) begin
        cap_addr  <= DM_address[MW-1:0];
        cap_data  <= DM_in;
        cap_write <= DM_write;
        cnt       <= CW'(LATENCY - 1);
      end else if ((state == BUSY) && (cnt != '0)) begin
        cnt <= cnt - CW'(1);
      end
      if (done && !cap_write) DM_out <= mem[cap_addr];
    end
  end

  // Array has no reset; a write pending when reset arrives is dropped.
  always_ff @(posedge clock) begin
    if (!reset && done && cap_write) mem[cap_addr] <= cap_data;
  end

  always_comb begin
    DM_ready = (state == RESP);
    DM_error = err;
  end

endmodule

// File: tb/tb_dm_responder.sv
// Scoreboard bench for dm_responder: three instances at latencies 1/2/3,
// shared stimulus, the instance under check selected per phase.
module tb_dm_responder;

  localparam int IGN = 0;
  localparam int ACC = 1;
  localparam int REJ = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0, rd = 1'b0, wr = 1'b0;
  logic [11:0] addr = '0;
  logic [31:0] din = '0;

  logic [31:0] out1, out2, out3;
  logic        rdy1, rdy2, rdy3, err1, err2, err3;

  always #5 clock = ~clock;

  dm_responder #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .DEPTH(2048), .LATENCY(1)) u_l1 (
    .clock(clock), .reset(reset), .DM_enable(en), .DM_read(rd), .DM_write(wr),
    .DM_address(addr), .DM_in(din), .DM_out(out1), .DM_ready(rdy1), .DM_error(err1));
  dm_responder #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .DEPTH(4096), .LATENCY(2)) u_l2 (
    .clock(clock), .reset(reset), .DM_enable(en), .DM_read(rd), .DM_write(wr),
    .DM_address(addr), .DM_in(din), .DM_out(out2), .DM_ready(rdy2), .DM_error(err2));
  dm_responder #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .DEPTH(4096), .LATENCY(3)) u_l3 (
    .clock(clock), .reset(reset), .DM_enable(en), .DM_read(rd), .DM_write(wr),
    .DM_address(addr), .DM_in(din), .DM_out(out3), .DM_ready(rdy3), .DM_error(err3));

  int          sel = 1;
  int          lat = 1;
  logic [31:0] out_s;
  logic        rdy_s, err_s;

  always_comb begin
    case (sel)
      1:       begin out_s = out1; rdy_s = rdy1; err_s = err1; end
      2:       begin out_s = out2; rdy_s = rdy2; err_s = err2; end
      default: begin out_s = out3; rdy_s = rdy3; err_s = err3; end
    endcase
  end

  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int unsigned cyc;
    bit          is_err;
    bit          is_read;
    logic [31:0] data;
  } exp_t;

  exp_t        sbq[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] out_exp = '0;
  bit          mon_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Pops one expectation per observed pulse; DM_out is checked every cycle.
  always @(negedge clock) begin
    exp_t e;
    if (reset) out_exp = '0;
    if (mon_en) begin
      if (rdy_s || err_s) begin
        check("ready_error_exclusive", {31'b0, rdy_s & err_s}, 32'd0);
        if (sbq.size() == 0) begin
          check("spurious_pulse", {30'b0, rdy_s, err_s}, 32'd0);
        end else begin
          e = sbq.pop_front();
          check("pulse_cycle", cyc, e.cyc);
          check("pulse_is_error", {31'b0, err_s}, {31'b0, e.is_err});
          if (e.is_read) out_exp = e.data;
        end
      end
      check("dm_out", out_s, out_exp);
    end
  end

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic issue(input bit r, input bit w, input logic [11:0] a,
                       input logic [31:0] d, input int kind, input logic [31:0] rdata);
    exp_t e;
    en = 1'b1; rd = r; wr = w; addr = a; din = d;
    if (kind == ACC) begin
      e.cyc = cyc + 1 + lat; e.is_err = 1'b0; e.is_read = r; e.data = rdata;
      sbq.push_back(e);
    end else if (kind == REJ) begin
      e.cyc = cyc + 1; e.is_err = 1'b1; e.is_read = 1'b0; e.data = '0;
      sbq.push_back(e);
    end
    step();
    en = 1'b0; rd = 1'b0; wr = 1'b0;
  endtask

  task automatic phase_start(input int k, input int l);
    mon_en = 1'b0;
    sel = k;
    lat = l;
    sbq.delete();
    reset = 1'b1;
    step();
    step();
    check("reset_ready", {31'b0, rdy_s}, 32'd0);
    check("reset_error", {31'b0, err_s}, 32'd0);
    check("reset_out", out_s, 32'd0);
    reset = 1'b0;
    mon_en = 1'b1;
    step();
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && sbq.size() != 0; i++) step();
    check("drain_pending", 32'(sbq.size()), 32'd0);
    repeat (2) step();
  endtask

  initial begin
    // Latency 1, DEPTH 2048
    phase_start(1, 1);
    issue(0, 1, 12'h005, 32'hDEADBEEF, ACC, '0);
    step();
    issue(1, 0, 12'h005, '0, ACC, 32'hDEADBEEF);
    drain();
    issue(0, 1, 12'h001, 32'hAAAA0001, ACC, '0); step();
    issue(0, 1, 12'h002, 32'hAAAA0002, ACC, '0); step();
    issue(0, 1, 12'h003, 32'hAAAA0003, ACC, '0); step();
    issue(1, 0, 12'h001, '0, ACC, 32'hAAAA0001); step();
    issue(1, 0, 12'h002, '0, ACC, 32'hAAAA0002); step();
    issue(1, 0, 12'h003, '0, ACC, 32'hAAAA0003);
    drain();
    issue(1, 1, 12'h005, '0, REJ, '0); step();
    issue(0, 0, 12'h005, '0, REJ, '0); step();
    issue(1, 0, 12'hFFF, '0, REJ, '0); step();
    issue(0, 1, 12'h800, 32'h0BADF00D, REJ, '0); step();
    issue(0, 1, 12'h7FF, 32'h7FF07FF0, ACC, '0); step();
    issue(1, 0, 12'h7FF, '0, ACC, 32'h7FF07FF0);
    drain();

    // Latency 3
    phase_start(3, 3);
    issue(0, 1, 12'h010, 32'h12345678, ACC, '0);
    repeat (3) step();
    issue(1, 0, 12'h010, '0, ACC, 32'h12345678);
    issue(0, 1, 12'h010, 32'hFFFFFFFF, IGN, '0);
    drain();
    repeat (5) step();
    issue(1, 0, 12'h010, '0, ACC, 32'h12345678);
    drain();

    // Latency 2: reset mid-BUSY and reset coinciding with a request
    phase_start(2, 2);
    issue(0, 1, 12'h020, 32'h11112222, ACC, '0);
    drain();
    issue(1, 0, 12'h020, '0, ACC, 32'h11112222);
    drain();
    issue(0, 1, 12'h020, 32'hA5A5A5A5, IGN, '0);
    reset = 1'b1;
    step();
    check("midbusy_reset_out", out_s, 32'd0);
    check("midbusy_reset_ready", {31'b0, rdy_s}, 32'd0);
    reset = 1'b0;
    repeat (4) step();
    reset = 1'b1;
    issue(1, 0, 12'h020, '0, IGN, '0);
    reset = 1'b0;
    repeat (4) step();
    issue(1, 0, 12'h020, '0, ACC, 32'h11112222);
    drain();

    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/dm_responder.md
Name: dm_responder

Overview:
- Responder end of the CPU data-memory interface. It accepts DM_enable/DM_read/DM_write requests from the core and serves them from an internal word-addressed array.
- Access latency is configurable. DM_ready pulses on completion, and DM_error pulses when a request is rejected.
- Sits beside the core in the SoC top, wired to DM_address, DM_in and DM_out.

Parameters:
- ADDR_WIDTH, 12, width of DM_address (word address).
- DATA_WIDTH, 32, width of DM_in and DM_out.
- DEPTH, 4096, number of implemented words. Must be <= 2^ADDR_WIDTH.
- LATENCY, 1, cycles from request acceptance to DM_ready. Must be >= 1.

Ports:
- clock  input  1  Single system clock. All logic is on the rising edge.
- reset  input  1  Synchronous, active-high reset.
- DM_enable  input  1  Request strobe.
- DM_read  input  1  Read request qualifier.
- DM_write  input  1  Write request qualifier.
- DM_address  input  ADDR_WIDTH  Word address.
- DM_in  input  DATA_WIDTH  Write data (core to memory).
- DM_out  output  DATA_WIDTH  Read data (memory to core). Registered.
- DM_ready  output  1  One-cycle completion pulse.
- DM_error  output  1  One-cycle reject pulse.

Behaviour:
- Reset: synchronous, active-high, sampled on the rising clock edge. Drives the FSM to IDLE, the counter to 0, DM_out=0, DM_ready=0, DM_error=0, and discards any captured request. Array contents are not cleared.
- FSM states: IDLE, BUSY, RESP.
- Request definition: a request is DM_enable=1 with exactly one of DM_read or DM_write set, and DM_address < DEPTH.
- Acceptance: a request is accepted only at an edge where the state is IDLE or RESP. On acceptance:
  - capture address, data and direction;
  - load counter = LATENCY-1;
  - go to BUSY.
- Reject: DM_enable=1 in IDLE or RESP with both or neither of read/write set, or with address >= DEPTH:
  - DM_error=1 for the next cycle only;
  - state becomes IDLE;
  - no array access, DM_out unchanged.
- BUSY: DM_enable, address and data are ignored (no capture, no error). The core must hold or re-issue the request after DM_ready.
  - Counter > 0: decrement and stay in BUSY.
  - Counter == 0: perform the access and go to RESP with DM_ready=1.
    - Write: array[addr] <= captured data.
    - Read: DM_out <= array[addr].
- Latency: DM_ready rises exactly LATENCY edges after the accepting edge and lasts one cycle. Read data is valid in DM_out in the same cycle as DM_ready.
- RESP: lasts one cycle, with DM_ready=1.
  - A new request in RESP is accepted (back-to-back operation, throughput one access per LATENCY+1 cycles, BUSY next).
  - An invalid request in RESP is rejected (DM_error pulses, state IDLE).
  - Otherwise go to IDLE.
- DM_out holding: DM_out holds its last read value through writes, idle periods and errors. It changes only on read completion or reset.
- Read after write: a read accepted in the RESP cycle of a write to the same address returns the new data, because the write committed at the RESP edge.
- DM_ready and DM_error are never asserted in the same cycle.
- Reset mid-BUSY: the pending access is dropped. A pending write is not committed and no DM_ready is produced.
- Simultaneous reset and request: reset wins; the request is not accepted.
- Address width: DM_address is used unsigned at full width. There is no wrap or aliasing above DEPTH; such addresses are rejected.

Test Plan:
- LATENCY=1. Write 0xDEADBEEF to address 0x005 in IDLE, then read 0x005 in the RESP cycle. Required: write DM_ready one edge after acceptance; read DM_ready one edge after its acceptance with DM_out=0xDEADBEEF; DM_error=0 throughout.
- LATENCY=3. Read address 0x010 preloaded with 0x12345678. Required: DM_ready is low for 2 cycles after acceptance and high in the 3rd; DM_out=0x12345678; DM_out stays stable through 5 subsequent idle cycles.
- LATENCY=3. While BUSY on a read of 0x010, issue a write of 0xFFFFFFFF to 0x010. Required: the write is ignored, the read returns the old value, and array[0x010] is unchanged on a later read.
- Send DM_enable with DM_read=DM_write=1, then DM_address=0xFFF with DEPTH=2048. Required: each produces a single-cycle DM_error, DM_ready never rises, and DM_out is unchanged.
- LATENCY=2. Write 0xA5A5A5A5 to 0x020, assert reset during BUSY, then read 0x020. Required: DM_out=0 and DM_ready=0 after reset; the read returns the prior contents, not 0xA5A5A5A5.
- LATENCY=1. Issue reads of 0x001, 0x002 and 0x003 back-to-back, each in the prior RESP cycle. Required: DM_ready is high every second cycle and DM_out steps through the three stored words in order.
